// File: rtl/pendulum_batch_sched_if.sv
// Bus bundle for pendulum_batch_sched: state-load, action, Compute-core and result streams.
// i_rst_sta is present only when PENDULUM_AUTO_RESET_EN is defined.
interface pendulum_batch_sched_if #(
    parameter int PE_NUM  = 8,
    parameter int ENV_NUM = 32,
    parameter int STA_WL  = 64,
    parameter int ACT_WL  = 32,
    parameter int OBS_WL  = 96,
    parameter int RWD_WL  = 32,
    parameter int GW      = ((ENV_NUM / PE_NUM) > 1) ? $clog2(ENV_NUM / PE_NUM) : 1
);
    logic                       i_init_valid;
    logic                       o_init_ready;
    logic [GW-1:0]              i_init_grp;
    logic [PE_NUM*STA_WL-1:0]   i_init_sta;

    logic                       i_act_valid;
    logic                       o_act_ready;
    logic [PE_NUM*ACT_WL-1:0]   i_act;

    logic                       o_core_ena;
    logic [PE_NUM*STA_WL-1:0]   o_core_sta;
    logic [PE_NUM*ACT_WL-1:0]   o_core_act;
    logic [PE_NUM*STA_WL-1:0]   i_core_sta;
    logic [PE_NUM*OBS_WL-1:0]   i_core_obs;
    logic [PE_NUM*RWD_WL-1:0]   i_core_rwd;
    logic [PE_NUM-1:0]          i_core_done;
    logic                       i_core_valid;

    logic                       o_res_valid;
    logic                       i_res_ready;
    logic [GW-1:0]              o_res_grp;
    logic [PE_NUM*OBS_WL-1:0]   o_obs;
    logic [PE_NUM*RWD_WL-1:0]   o_rwd;
    logic [PE_NUM-1:0]          o_done;
    logic                       o_batch_done;
`ifdef PENDULUM_AUTO_RESET_EN
    logic [STA_WL-1:0]          i_rst_sta;
`endif

    modport slave (
`ifdef PENDULUM_AUTO_RESET_EN
        input  i_rst_sta,
`endif
        input  i_init_valid, i_init_grp, i_init_sta,
        input  i_act_valid, i_act,
        input  i_core_sta, i_core_obs, i_core_rwd, i_core_done, i_core_valid,
        input  i_res_ready,
        output o_init_ready, o_act_ready,
        output o_core_ena, o_core_sta, o_core_act,
        output o_res_valid, o_res_grp, o_obs, o_rwd, o_done, o_batch_done
    );

    modport master (
`ifdef PENDULUM_AUTO_RESET_EN
        output i_rst_sta,
`endif
        output i_init_valid, i_init_grp, i_init_sta,
        output i_act_valid, i_act,
        output i_core_sta, i_core_obs, i_core_rwd, i_core_done, i_core_valid,
        output i_res_ready,
        input  o_init_ready, o_act_ready,
        input  o_core_ena, o_core_sta, o_core_act,
        input  o_res_valid, o_res_grp, o_obs, o_rwd, o_done, o_batch_done
    );
endinterface

// File: rtl/pendulum_batch_sched.sv
// Time-multiplexes ENV_NUM Pendulum environments over a PE_NUM-lane Compute core, one group per step.
// Optional PENDULUM_AUTO_RESET_EN: lanes that finish an episode reload their state from i_rst_sta.

// One lane: holds this lane's state and step counter for every group.
module pbs_lane #(
    parameter int GRP_NUM   = 4,
    parameter int GW        = 2,
    parameter int STA_WL    = 64,
    parameter int STEP_WL   = 8,
    parameter int MAX_STEPS = 200
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld_we,
    input  logic [GW-1:0]     i_ld_grp,
    input  logic [STA_WL-1:0] i_ld_sta,
    input  logic              i_wb_we,
    input  logic [GW-1:0]     i_grp,
    input  logic [STA_WL-1:0] i_core_sta,
    input  logic              i_core_done,
    input  logic              i_auto_en,
    input  logic [STA_WL-1:0] i_rst_sta,
    output logic [STA_WL-1:0] o_sta,
    output logic              o_done
);
    logic [STA_WL-1:0]  r_sta [GRP_NUM];
    logic [STEP_WL-1:0] r_cnt [GRP_NUM];
    logic               r_done;
    logic               w_trunc;
    logic               w_done;
    logic [STA_WL-1:0]  w_wb_sta;

    assign w_trunc  = (r_cnt[i_grp] == STEP_WL'(MAX_STEPS - 1));
    assign w_done   = i_core_done | w_trunc;
    assign w_wb_sta = (i_auto_en && w_done) ? i_rst_sta : i_core_sta;
    assign o_sta    = r_sta[i_grp];
    assign o_done   = r_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int g = 0; g < GRP_NUM; g++) begin
                r_sta[g] <= '0;
                r_cnt[g] <= '0;
            end
            r_done <= 1'b0;
        end else begin
            if (i_ld_we) begin
                r_sta[i_ld_grp] <= i_ld_sta;
                r_cnt[i_ld_grp] <= '0;
            end
            if (i_wb_we) begin
                r_sta[i_grp] <= w_wb_sta;
                r_cnt[i_grp] <= w_done ? '0 : r_cnt[i_grp] + STEP_WL'(1);
                r_done       <= w_done;
            end
        end
    end
endmodule

module pendulum_batch_sched #(
    parameter int PE_NUM    = 8,
    parameter int ENV_NUM   = 32,
    parameter int STA_WL    = 64,
    parameter int ACT_WL    = 32,
    parameter int OBS_WL    = 96,
    parameter int RWD_WL    = 32,
    parameter int MAX_STEPS = 200,
    parameter int STEP_WL   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pendulum_batch_sched_if.slave io_bus
);
    localparam int GRP_NUM = ENV_NUM / PE_NUM;
    localparam int GW      = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACT   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]                     r_state;
    logic [GW-1:0]                  r_ptr;
    logic [GW-1:0]                  r_res_grp;
    logic [PE_NUM-1:0][STA_WL-1:0]  r_core_sta;
    logic [PE_NUM*ACT_WL-1:0]       r_core_act;
    logic [PE_NUM*OBS_WL-1:0]       r_obs;
    logic [PE_NUM*RWD_WL-1:0]       r_rwd;
    logic                           r_batch_done;

    logic [PE_NUM-1:0][STA_WL-1:0]  w_init_sta;
    logic [PE_NUM-1:0][STA_WL-1:0]  w_core_sta;
    logic [PE_NUM-1:0][STA_WL-1:0]  w_lane_sta;
    logic [PE_NUM-1:0]              w_lane_done;
    logic                           w_ld_hs;
    logic                           w_core_hs;
    logic                           w_last;
    logic                           w_auto_en;
    logic [STA_WL-1:0]              w_rst_sta;

`ifdef PENDULUM_AUTO_RESET_EN
    assign w_auto_en = 1'b1;
    assign w_rst_sta = io_bus.i_rst_sta;
`else
    assign w_auto_en = 1'b0;
    assign w_rst_sta = '0;
`endif

    assign w_init_sta = io_bus.i_init_sta;
    assign w_core_sta = io_bus.i_core_sta;
    assign w_ld_hs    = (r_state == S_IDLE) && io_bus.i_init_valid;
    // Core results outside WAIT are stray strobes and never touch the store.
    assign w_core_hs  = (r_state == S_WAIT) && io_bus.i_core_valid;
    assign w_last     = (r_ptr == GW'(GRP_NUM - 1));

    for (genvar l = 0; l < PE_NUM; l++) begin : g_lane
        pbs_lane #(
            .GRP_NUM   (GRP_NUM),
            .GW        (GW),
            .STA_WL    (STA_WL),
            .STEP_WL   (STEP_WL),
            .MAX_STEPS (MAX_STEPS)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_ld_we     (w_ld_hs),
            .i_ld_grp    (io_bus.i_init_grp),
            .i_ld_sta    (w_init_sta[l]),
            .i_wb_we     (w_core_hs),
            .i_grp       (r_ptr),
            .i_core_sta  (w_core_sta[l]),
            .i_core_done (io_bus.i_core_done[l]),
            .i_auto_en   (w_auto_en),
            .i_rst_sta   (w_rst_sta),
            .o_sta       (w_lane_sta[l]),
            .o_done      (w_lane_done[l])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_res_grp    <= '0;
            r_core_sta   <= '0;
            r_core_act   <= '0;
            r_obs        <= '0;
            r_rwd        <= '0;
            r_batch_done <= 1'b0;
        end else begin
            r_batch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!io_bus.i_init_valid && io_bus.i_act_valid)
                        r_state <= S_ACT;
                end
                S_ACT: begin
                    // Snapshot the group's state here so the core sees it unchanged until results return.
                    if (io_bus.i_act_valid) begin
                        r_core_act <= io_bus.i_act;
                        r_core_sta <= w_lane_sta;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (io_bus.i_core_valid) begin
                        r_obs     <= io_bus.i_core_obs;
                        r_rwd     <= io_bus.i_core_rwd;
                        r_res_grp <= r_ptr;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (io_bus.i_res_ready) begin
                        if (w_last) begin
                            r_ptr        <= '0;
                            r_batch_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_ptr   <= r_ptr + GW'(1);
                            r_state <= S_ACT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.o_init_ready = (r_state == S_IDLE);
    assign io_bus.o_act_ready  = (r_state == S_ACT);
    assign io_bus.o_core_ena   = (r_state == S_ISSUE);
    assign io_bus.o_res_valid  = (r_state == S_OUT);
    assign io_bus.o_core_sta   = r_core_sta;
    assign io_bus.o_core_act   = r_core_act;
    assign io_bus.o_res_grp    = r_res_grp;
    assign io_bus.o_obs        = r_obs;
    assign io_bus.o_rwd        = r_rwd;
    assign io_bus.o_done       = w_lane_done;
    assign io_bus.o_batch_done = r_batch_done;
endmodule

// File: tb/tb_pendulum_batch_sched.sv
// Randomized bench for pendulum_batch_sched with a per-environment store/counter reference model.
// Covers reset, group ordering, truncation, back-pressure, mid-batch reset and optional auto-reset.
module tb_pendulum_batch_sched;
    localparam int PE   = 8;
    localparam int ENV  = 32;
    localparam int GRP  = ENV / PE;
    localparam int GW   = 2;
    localparam int SW   = 64;
    localparam int AW   = 32;
    localparam int OW   = 96;
    localparam int RW   = 32;
    localparam int MAXS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pendulum_batch_sched_if #(.PE_NUM(PE), .ENV_NUM(ENV), .STA_WL(SW), .ACT_WL(AW),
                              .OBS_WL(OW), .RWD_WL(RW), .GW(GW)) bus();

    pendulum_batch_sched #(.PE_NUM(PE), .ENV_NUM(ENV), .STA_WL(SW), .ACT_WL(AW),
                           .OBS_WL(OW), .RWD_WL(RW), .MAX_STEPS(MAXS), .STEP_WL(8))
        dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one state word and one step count per environment.
    logic [SW-1:0] m_sta [ENV];
    int            m_cnt [ENV];
`ifdef PENDULUM_AUTO_RESET_EN
    logic [SW-1:0] rst_sta_v;
`endif

    function automatic logic [1023:0] rnd_wide();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        for (int e = 0; e < ENV; e++) begin
            m_sta[e] = '0;
            m_cnt[e] = 0;
        end
    endtask

    task automatic load_group(input int g, input logic [PE-1:0][SW-1:0] sta);
        int to;
        bus.i_init_valid = 1'b1;
        bus.i_init_grp   = GW'(g);
        bus.i_init_sta   = sta;
        to = 0;
        while (bus.o_init_ready !== 1'b1 && to < 20) begin
            @(negedge clk);
            to++;
        end
        n_chk++;
        if (to >= 20) begin
            n_fail++;
            $display("FAIL init_timeout: o_init_ready=%b required 1", bus.o_init_ready);
        end
        @(negedge clk);
        bus.i_init_valid = 1'b0;
        for (int l = 0; l < PE; l++) begin
            m_sta[g*PE + l] = sta[l];
            m_cnt[g*PE + l] = 0;
        end
    endtask

    task automatic load_all();
        logic [1023:0] w;
        for (int g = 0; g < GRP; g++) begin
            w = rnd_wide();
            load_group(g, w[PE*SW-1:0]);
        end
    endtask

    // Steps one group: action handshake, issue, core response after lat cycles, result handshake.
    task automatic step_group(input int g, input int mode, input int lat, input int stall, input bit dir);
        logic [PE-1:0][AW-1:0] act;
        logic [PE-1:0][SW-1:0] exp_sta;
        logic [PE-1:0][SW-1:0] nsta;
        logic [PE*OW-1:0]      obs;
        logic [PE*RW-1:0]      rwd;
        logic [PE-1:0]         cdone;
        logic [PE-1:0]         exp_done;
        logic                  exp_bd;
        logic [1023:0]         w;
        int                    to;
        w = rnd_wide();
        act = w[PE*AW-1:0];
        if (dir) act[0] = 32'h3f44c360;
        for (int l = 0; l < PE; l++) exp_sta[l] = m_sta[g*PE + l];
        bus.i_act       = act;
        bus.i_act_valid = 1'b1;
        to = 0;
        while (bus.o_act_ready !== 1'b1 && to < 20) begin
            @(negedge clk);
            to++;
        end
        if (to >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL act_timeout: group %0d o_act_ready=%b required 1", g, bus.o_act_ready);
            bus.i_act_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.i_act_valid = 1'b0;
        n_chk++;
        if (bus.o_core_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ena: group %0d o_core_ena=%b required 1", g, bus.o_core_ena);
        end
        n_chk++;
        if (bus.o_core_sta !== exp_sta) begin
            n_fail++;
            $display("FAIL issue_sta: group %0d got %h required %h", g, bus.o_core_sta, exp_sta);
        end
        n_chk++;
        if (bus.o_core_act !== act) begin
            n_fail++;
            $display("FAIL issue_act: group %0d got %h required %h", g, bus.o_core_act, act);
        end
        for (int i = 0; i < lat; i++) @(negedge clk);
        n_chk++;
        if (bus.o_core_ena !== 1'b0 || bus.o_core_sta !== exp_sta || bus.o_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_hold: group %0d ena=%b res_valid=%b sta=%h required ena=0 res_valid=0 sta=%h",
                     g, bus.o_core_ena, bus.o_res_valid, bus.o_core_sta, exp_sta);
        end
        w = rnd_wide(); nsta = w[PE*SW-1:0];
        w = rnd_wide(); obs  = w[PE*OW-1:0];
        w = rnd_wide(); rwd  = w[PE*RW-1:0];
        case (mode)
            0:       cdone = '0;
            1:       cdone = PE'($urandom);
            default: cdone = (g == 0) ? PE'(4) : '0;
        endcase
        for (int l = 0; l < PE; l++) begin
            int e;
            e = g*PE + l;
            exp_done[l] = cdone[l] || (m_cnt[e] == MAXS - 1);
            m_cnt[e]    = exp_done[l] ? 0 : m_cnt[e] + 1;
`ifdef PENDULUM_AUTO_RESET_EN
            m_sta[e]    = exp_done[l] ? rst_sta_v : nsta[l];
`else
            m_sta[e]    = nsta[l];
`endif
        end
        bus.i_core_sta   = nsta;
        bus.i_core_obs   = obs;
        bus.i_core_rwd   = rwd;
        bus.i_core_done  = cdone;
`ifdef PENDULUM_AUTO_RESET_EN
        bus.i_rst_sta    = rst_sta_v;
`endif
        bus.i_core_valid = 1'b1;
        @(negedge clk);
        bus.i_core_valid = 1'b0;
        bus.i_core_sta   = ~nsta;
        bus.i_core_obs   = ~obs;
        bus.i_core_rwd   = ~rwd;
        bus.i_core_done  = ~cdone;
        n_chk++;
        if (bus.o_res_valid !== 1'b1 || bus.o_res_grp !== GW'(g)) begin
            n_fail++;
            $display("FAIL res_beat: res_valid=%b grp=%0d required 1 grp=%0d", bus.o_res_valid, bus.o_res_grp, g);
        end
        n_chk++;
        if (bus.o_obs !== obs || bus.o_rwd !== rwd) begin
            n_fail++;
            $display("FAIL res_obs_rwd: group %0d obs=%h rwd=%h required obs=%h rwd=%h", g, bus.o_obs, bus.o_rwd, obs, rwd);
        end
        n_chk++;
        if (bus.o_done !== exp_done) begin
            n_fail++;
            $display("FAIL res_done: group %0d got %b required %b", g, bus.o_done, exp_done);
        end
        for (int s = 0; s < stall; s++) begin
            if (s == 0) bus.i_core_valid = 1'b1;
            @(negedge clk);
            bus.i_core_valid = 1'b0;
            n_chk++;
            if (bus.o_res_valid !== 1'b1 || bus.o_obs !== obs || bus.o_rwd !== rwd || bus.o_done !== exp_done ||
                bus.o_act_ready !== 1'b0 || bus.o_core_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d res_valid=%b act_ready=%b ena=%b done=%b required 1 0 0 %b",
                         s, bus.o_res_valid, bus.o_act_ready, bus.o_core_ena, bus.o_done, exp_done);
            end
        end
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        bus.i_res_ready = 1'b0;
        exp_bd = (g == GRP - 1);
        n_chk++;
        if (bus.o_res_valid !== 1'b0 || bus.o_batch_done !== exp_bd) begin
            n_fail++;
            $display("FAIL res_handshake: group %0d res_valid=%b batch_done=%b required 0 %b",
                     g, bus.o_res_valid, bus.o_batch_done, exp_bd);
        end
        if (exp_bd) begin
            @(negedge clk);
            n_chk++;
            if (bus.o_batch_done !== 1'b0 || bus.o_init_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL batch_pulse: batch_done=%b init_ready=%b required 0 1", bus.o_batch_done, bus.o_init_ready);
            end
        end
    endtask

    task automatic run_batch(input int mode, input int stall_g, input int stall_n, input bit dir);
        for (int g = 0; g < GRP; g++)
            step_group(g, mode, $urandom_range(1, 4), (g == stall_g) ? stall_n : 0, dir && (g == 0));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.o_init_ready !== 1'b1 || bus.o_act_ready !== 1'b0 || bus.o_core_ena !== 1'b0 ||
            bus.o_res_valid !== 1'b0 || bus.o_batch_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: init=%b act=%b ena=%b res=%b bd=%b required 1 0 0 0 0", bus.o_init_ready,
                     bus.o_act_ready, bus.o_core_ena, bus.o_res_valid, bus.o_batch_done);
        end
        n_chk++;
        if (bus.o_obs !== '0 || bus.o_rwd !== '0 || bus.o_done !== '0 || bus.o_res_grp !== '0) begin
            n_fail++;
            $display("FAIL reset_data: obs=%h rwd=%h done=%b grp=%0d required all zero", bus.o_obs, bus.o_rwd, bus.o_done, bus.o_res_grp);
        end
        rst = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_directed();
        logic [1023:0]         w;
        logic [PE-1:0][SW-1:0] sta;
        load_all();
        w = rnd_wide();
        sta = w[PE*SW-1:0];
        sta[0] = 64'hc039e509c024bece;
        load_group(0, sta);
        run_batch(1, -1, 0, 1'b1);
        run_batch(1, -1, 0, 1'b0);
    endtask

    task automatic test_truncation();
        load_all();
        run_batch(0, -1, 0, 1'b0);
        run_batch(0, -1, 0, 1'b0);
        n_chk++;
        if (bus.o_done !== '0) begin
            n_fail++;
            $display("FAIL trunc_batch2: done=%b required 0", bus.o_done);
        end
        run_batch(0, -1, 0, 1'b0);
        n_chk++;
        if (bus.o_done !== '1) begin
            n_fail++;
            $display("FAIL trunc_batch3: done=%b required all ones", bus.o_done);
        end
        run_batch(0, -1, 0, 1'b0);
        n_chk++;
        if (bus.o_done !== '0) begin
            n_fail++;
            $display("FAIL trunc_batch4: done=%b required 0", bus.o_done);
        end
    endtask

    task automatic test_back_to_back();
        run_batch(1, 1, 10, 1'b0);
        for (int i = 0; i < 6; i++)
            run_batch(1, $urandom_range(0, GRP - 1), $urandom_range(0, 5), 1'b0);
    endtask

    task automatic test_reset_mid();
        int to;
        bus.i_act_valid = 1'b1;
        to = 0;
        while (bus.o_act_ready !== 1'b1 && to < 20) begin
            @(negedge clk);
            to++;
        end
        @(negedge clk);
        bus.i_act_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (bus.o_init_ready !== 1'b1 || bus.o_act_ready !== 1'b0 || bus.o_core_ena !== 1'b0 ||
            bus.o_res_valid !== 1'b0 || bus.o_batch_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: init=%b act=%b ena=%b res=%b bd=%b required 1 0 0 0 0", bus.o_init_ready,
                     bus.o_act_ready, bus.o_core_ena, bus.o_res_valid, bus.o_batch_done);
        end
        n_chk++;
        if (bus.o_obs !== '0 || bus.o_rwd !== '0 || bus.o_done !== '0 || bus.o_res_grp !== '0) begin
            n_fail++;
            $display("FAIL midreset_data: obs=%h rwd=%h done=%b grp=%0d required all zero", bus.o_obs, bus.o_rwd, bus.o_done, bus.o_res_grp);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        bus.i_core_valid = 1'b1;
        @(negedge clk);
        bus.i_core_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.o_res_valid !== 1'b0 || bus.o_init_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_stray: res_valid=%b init_ready=%b required 0 1", bus.o_res_valid, bus.o_init_ready);
        end
        run_batch(1, -1, 0, 1'b0);
    endtask

`ifdef PENDULUM_AUTO_RESET_EN
    task automatic test_auto_reset();
        load_all();
        rst_sta_v = '0;
        run_batch(2, -1, 0, 1'b0);
        run_batch(0, -1, 0, 1'b0);
        rst_sta_v = {$urandom, $urandom};
        run_batch(1, -1, 0, 1'b0);
    endtask
`endif

    initial begin
        bus.i_init_valid = 1'b0;
        bus.i_init_grp   = '0;
        bus.i_init_sta   = '0;
        bus.i_act_valid  = 1'b0;
        bus.i_act        = '0;
        bus.i_core_sta   = '0;
        bus.i_core_obs   = '0;
        bus.i_core_rwd   = '0;
        bus.i_core_done  = '0;
        bus.i_core_valid = 1'b0;
        bus.i_res_ready  = 1'b0;
`ifdef PENDULUM_AUTO_RESET_EN
        rst_sta_v        = {$urandom, $urandom};
        bus.i_rst_sta    = rst_sta_v;
`endif
        test_reset();
        test_directed();
        test_truncation();
        test_back_to_back();
        test_reset_mid();
`ifdef PENDULUM_AUTO_RESET_EN
        test_auto_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pendulum_batch_sched.md
Name: pendulum_batch_sched

Overview:
- Steps ENV_NUM Pendulum environments on a PE_NUM-lane Compute core by time-multiplexing ENV_NUM/PE_NUM groups.
- Owns the per-environment state store and per-environment episode step counters; applies episode truncation.
- Sits between the agent-side action/result streams and the Compute core. Generalises the fixed 40-env, single-shot Compute usage to a parametrised, back-pressured batch pipeline.

Parameters:
- PE_NUM, 8, lanes per Compute core.
- ENV_NUM, 32, environments held; must be an integer multiple of PE_NUM.
- STA_WL, 64, state word {th_dot, th} as float32 pair.
- ACT_WL, 32, action word (float32 torque).
- OBS_WL, 96, observation word {th_dot, sin, cos}.
- RWD_WL, 32, reward word (float32).
- MAX_STEPS, 200, truncation length in steps; range 1..2^STEP_WL-1.
- STEP_WL, 8, per-environment step counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_init_valid  in  1  state-load beat valid.
- o_init_ready  out  1  state-load ready; high only in IDLE.
- i_init_grp  in  GW  group index for the load beat. GW = max(1, clog2(ENV_NUM/PE_NUM)).
- i_init_sta  in  PE_NUM*STA_WL  states for the loaded group.
- i_act_valid  in  1  action beat valid; one beat per group, in ascending group order.
- o_act_ready  out  1  action ready.
- i_act  in  PE_NUM*ACT_WL  actions for the current group.
- o_core_ena  out  1  one-cycle start pulse to the core.
- o_core_sta  out  PE_NUM*STA_WL  group states to the core.
- o_core_act  out  PE_NUM*ACT_WL  group actions to the core.
- i_core_sta  in  PE_NUM*STA_WL  next states from the core.
- i_core_obs  in  PE_NUM*OBS_WL  observations from the core.
- i_core_rwd  in  PE_NUM*RWD_WL  rewards from the core.
- i_core_done  in  PE_NUM  terminal flags from the core.
- i_core_valid  in  1  core result strobe; arrives at any latency of 1 or more cycles after o_core_ena.
- o_res_valid  out  1  result beat valid.
- i_res_ready  in  1  result ready.
- o_res_grp  out  GW  group index of the result beat.
- o_obs  out  PE_NUM*OBS_WL  observations.
- o_rwd  out  PE_NUM*RWD_WL  rewards.
- o_done  out  PE_NUM  done flags (core done OR truncation).
- o_batch_done  out  1  one-cycle pulse after the last group's result handshake.

Behaviour:
- Reset (async, i_rst=1): FSM=IDLE; group pointer=0; all step counters=0; state store=0. o_init_ready=1. o_act_ready, o_core_ena, o_res_valid, o_batch_done=0. o_obs, o_rwd, o_done, o_res_grp=0.
- FSM states: IDLE, ACT, ISSUE, WAIT, OUT.
- IDLE:
  - A load handshake writes i_init_sta into group i_init_grp and clears that group's step counters.
  - If i_act_valid=1 with no load beat present: go to ACT. A load beat takes priority in the same cycle.
- ACT: o_act_ready=1. On handshake, latch i_act, then ISSUE.
- ISSUE: o_core_ena=1 for exactly one cycle. o_core_sta and o_core_act are stable from this cycle until i_core_valid. Then WAIT.
- WAIT:
  - On i_core_valid, register obs and rwd.
  - Per lane: trunc = (cnt == MAX_STEPS-1); done = i_core_done | trunc.
  - Counter becomes 0 if done, otherwise cnt+1. Write i_core_sta back to the store. Go to OUT.
  - i_core_valid in any other state is ignored.
- OUT:
  - o_res_valid=1; outputs are held stable until i_res_ready.
  - On handshake: if this is the last group, pointer=0, pulse o_batch_done, go to IDLE. Otherwise pointer+1, go to ACT.
- Round-trip latency per group: ISSUE is entered the cycle after the action handshake. The result is valid the cycle after i_core_valid.
- Back-pressure: i_res_ready held low stalls the FSM indefinitely with no state loss.
- A reset mid-batch aborts the batch; the state store is cleared. The host must reload before stepping.
- Counter arithmetic is unsigned and never exceeds MAX_STEPS-1.

Optional Feature:
- Macro PENDULUM_AUTO_RESET_EN.
- When defined: an extra input i_rst_sta (STA_WL wide). On a lane with done=1, the store is written with i_rst_sta instead of i_core_sta. o_obs still reports the terminal step.
- When undefined: no such port, and i_core_sta is always written back.

Test Plan:
- Load group 0 lane 0 with {th_dot=0xc039e509, th=0xc024bece}, action 0x3f44c360, core model returns its next state -> o_core_sta lane0=0xc039e509c024bece during ISSUE; o_res_grp=0; next step issues the returned state.
- ENV_NUM=32, PE_NUM=8, all beats accepted -> 4 result beats with o_res_grp 0,1,2,3, then o_batch_done pulses once, one cycle after the 4th handshake.
- MAX_STEPS=3, core done=0 -> o_done=all-ones on the 3rd batch only; counters read 0 afterwards.
- Hold i_res_ready=0 for 10 cycles in OUT -> o_res_valid stays 1, outputs unchanged, o_act_ready=0, no o_core_ena.
- Assert i_rst during WAIT -> all outputs go to reset values immediately; a later i_core_valid is ignored.
- With PENDULUM_AUTO_RESET_EN, i_rst_sta=0, core done lane 2 -> the next step issues state 0 on lane 2 while other lanes carry their core next state.
